// File: rtl/data_memory.sv
// data_memory: wait-stated word memory with a one-entry posted write buffer.
// Optional load forwarding from the buffer is enabled by defining DMEM_FORWARD_EN.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module data_memory #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     read,
   input  logic                     write,
   input  logic [`ADDRESS_SIZE-1:0] address,
   input  logic [`DATA_SIZE-1:0]    data_in,
   output logic [`DATA_SIZE-1:0]    data_out,
   output logic                     valid,
   output logic                     stall
);
   localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, READ_WAIT, RESPOND} state_t;
   state_t state, state_next;

   logic [`DATA_SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]         word_addr, rd_addr, wb_addr;
   logic [`DATA_SIZE-1:0] wb_data;
   logic                  wb_valid;
   logic [3:0]            wb_count, rd_count;
   logic                  wr_accept, wb_commit, rd_start, fwd_hit;

   assign word_addr = address[AW-1:0];
   assign wr_accept = (state == IDLE) && write && !wb_valid;
   assign wb_commit = wb_valid && (wb_count == 4'd0);
   // A read only reaches the array once the buffer is empty, so no read-during-write hazard exists.
   assign rd_start  = (state == IDLE) && !write && read && !wb_valid;
`ifdef DMEM_FORWARD_EN
   assign fwd_hit   = (state == IDLE) && !write && read && wb_valid && (word_addr == wb_addr);
`else
   assign fwd_hit   = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (rd_start)     state_next = READ_WAIT;
            else if (fwd_hit) state_next = RESPOND;
         end
         READ_WAIT: if (rd_count == 4'd0) state_next = RESPOND;
         RESPOND:   state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Writes win over reads; a blocked write or any read in IDLE freezes the pipe.
   always_comb begin
      stall = 1'b0;
      if (reset) begin
         case (state)
            IDLE:      stall = write ? wb_valid : read;
            READ_WAIT: stall = 1'b1;
            default:   stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_addr  <= '0;
         rd_count <= 4'd0;
         data_out <= '0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (rd_start) begin
            rd_addr  <= word_addr;
            rd_count <= WS;
         end else if (state == READ_WAIT && rd_count != 4'd0) begin
            rd_count <= rd_count - 4'd1;
         end
         if (state == READ_WAIT && rd_count == 4'd0) begin
            data_out <= mem[rd_addr];
            valid    <= 1'b1;
         end else if (fwd_hit) begin
            data_out <= wb_data;
            valid    <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wb_valid <= 1'b0;
         wb_count <= 4'd0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else if (wr_accept) begin
         wb_valid <= 1'b1;
         wb_count <= WS;
         wb_addr  <= word_addr;
         wb_data  <= data_in;
      end else if (wb_valid) begin
         if (wb_count != 4'd0) wb_count <= wb_count - 4'd1;
         else                  wb_valid <= 1'b0;
      end
   end

   // The array is never cleared; reset only drops a store that has not committed yet.
   always_ff @(posedge clock) begin
      if (reset && wb_commit) mem[wb_addr] <= wb_data;
   end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory (DEPTH=256, WAIT_STATES=2) with a cycle-level
// reference model of buffer occupancy, read latency and memory contents.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module tb_data_memory;
   localparam int W     = 2;
   localparam int DEPTH = 256;
   localparam int AS    = `ADDRESS_SIZE;
   localparam int DS    = `DATA_SIZE;
`ifdef DMEM_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clock = 1'b0, reset = 1'b0, read = 1'b0, write = 1'b0;
   logic [AS-1:0] address = '0;
   logic [DS-1:0] data_in = '0;
   logic [DS-1:0] data_out;
   logic          valid, stall;

   data_memory #(.DEPTH(DEPTH), .WAIT_STATES(W)) dut (
      .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
      .data_in(data_in), .data_out(data_out), .valid(valid), .stall(stall)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Reference model: word contents, plus the occupancy window of the posted store.
   logic [DS-1:0] ref_mem [DEPTH];
   bit            written [DEPTH];
   int            free_at = 0;
   bit            pend = 1'b0;
   int            pend_idx = 0;
   logic [DS-1:0] pend_old;
   bit            pend_old_wr;
   int            n_cmp = 0, n_err = 0;

   task automatic do_write(input logic [AS-1:0] a, input logic [DS-1:0] d, input bit also_read,
                           input string tag);
      int s0, stalls, exp, idx;
      idx = int'(a) % DEPTH;
      read = also_read; write = 1'b1; address = a; data_in = d;
      stalls = 0;
      @(negedge clock); s0 = cyc;
      while (stall === 1'b1 && stalls < 40) begin
         stalls++;
         @(negedge clock);
      end
      exp = (free_at > s0) ? free_at - s0 : 0;
      n_cmp++;
      if (stalls !== exp) begin
         n_err++; $display("FAIL %s write_stall: got %0d expected %0d", tag, stalls, exp);
      end
      n_cmp++;
      if (valid !== 1'b0) begin
         n_err++; $display("FAIL %s write_valid: got %b expected 0", tag, valid);
      end
      pend = 1'b1; pend_idx = idx; pend_old = ref_mem[idx]; pend_old_wr = written[idx];
      ref_mem[idx] = d; written[idx] = 1'b1;
      free_at = cyc + W + 2;
      @(posedge clock); #1;
      read = 1'b0; write = 1'b0;
   endtask

   task automatic do_read(input logic [AS-1:0] a, input string tag);
      int s0, stalls, exp, idx;
      bit buffered;
      idx = int'(a) % DEPTH;
      read = 1'b1; write = 1'b0; address = a;
      stalls = 0;
      @(negedge clock); s0 = cyc;
      while (stall === 1'b1 && stalls < 40) begin
         stalls++;
         @(negedge clock);
      end
      buffered = pend && (s0 < free_at);
      if (FWD && buffered && idx == pend_idx) exp = 1;
      else exp = ((free_at > s0) ? free_at - s0 : 0) + W + 2;
      n_cmp++;
      if (stalls !== exp) begin
         n_err++; $display("FAIL %s read_stall: got %0d expected %0d", tag, stalls, exp);
      end
      n_cmp++;
      if (valid !== 1'b1) begin
         n_err++; $display("FAIL %s read_valid: got %b expected 1", tag, valid);
      end
      n_cmp++;
      if (data_out !== ref_mem[idx]) begin
         n_err++; $display("FAIL %s read_data: got %h expected %h", tag, data_out, ref_mem[idx]);
      end
      @(posedge clock); #1;
      read = 1'b0;
   endtask

   task automatic idle_check(input int n, input string tag);
      read = 1'b0; write = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         n_cmp++;
         if (valid !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL %s idle: got valid=%b stall=%b expected 0/0", tag, valid, stall);
         end
         @(posedge clock); #1;
      end
   endtask

   // Holds reset low for one edge with both requests raised, which must all be ignored.
   task automatic pulse_reset(input string tag);
      int r;
      reset = 1'b0; read = 1'b1; write = 1'b1;
      @(negedge clock); r = cyc;
      n_cmp++;
      if (stall !== 1'b0) begin
         n_err++; $display("FAIL %s reset_stall: got %b expected 0", tag, stall);
      end
      @(posedge clock); #1;
      reset = 1'b1; read = 1'b0; write = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (valid !== 1'b0 || data_out !== '0) begin
         n_err++; $display("FAIL %s reset_out: got valid=%b data=%h expected 0/0", tag, valid, data_out);
      end
      if (pend && r < free_at) begin
         ref_mem[pend_idx] = pend_old; written[pend_idx] = pend_old_wr;
      end
      pend = 1'b0; free_at = 0;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; read = 1'b1; write = 1'b1; address = 16'h0010; data_in = 32'hFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_cmp++;
         if (stall !== 1'b0) begin
            n_err++; $display("FAIL reset_hold_stall: got %b expected 0", stall);
         end
         if (i > 0) begin
            n_cmp++;
            if (valid !== 1'b0 || data_out !== '0) begin
               n_err++; $display("FAIL reset_hold_out: got valid=%b data=%h expected 0/0", valid, data_out);
            end
         end
      end
      @(posedge clock); #1;
      reset = 1'b1; read = 1'b0; write = 1'b0;
      idle_check(2, "after_reset");
   endtask

   task automatic test_write_read();
      do_write(16'h0010, 32'h1234, 1'b0, "wr10");
      idle_check(3, "drain10");
      do_read(16'h0010, "rd10");
   endtask

   task automatic test_read_write_both();
      do_write(16'h0020, 32'hBEEF, 1'b1, "both20");
      idle_check(W + 4, "both20_novalid");
      do_read(16'h0020, "rd20");
   endtask

   task automatic test_back_to_back();
      do_write(16'h0030, 32'hAAAA, 1'b0, "wr30");
      do_write(16'h0031, 32'h5555, 1'b0, "wr31");
      do_read(16'h0030, "rd30");
      do_read(16'h0031, "rd31");
   endtask

   task automatic test_forward();
      do_write(16'h0040, 32'hCAFE, 1'b0, "wr40");
      do_read(16'h0040, "rd40_hazard");
      idle_check(3, "drain40");
      do_read(16'h0040, "rd40_again");
   endtask

   task automatic test_reset_abort();
      do_write(16'h0050, 32'h2222, 1'b0, "wr50_old");
      idle_check(4, "drain50");
      do_write(16'h0050, 32'h1111, 1'b0, "wr50_new");
      pulse_reset("rst_buffered");
      do_read(16'h0050, "rd50_kept");
      // Start a read, let it reach its wait phase, then abort it.
      read = 1'b1; write = 1'b0; address = 16'h0010;
      @(posedge clock); #1;
      pulse_reset("rst_readwait");
      idle_check(W + 4, "abort_novalid");
      do_read(16'h0010, "rd10_after_abort");
   endtask

   task automatic test_alias();
      do_write(16'h01FF, 32'h0BAD_F00D, 1'b0, "wr1ff");
      idle_check(3, "drain1ff");
      do_read(16'h00FF, "rd0ff_alias");
      do_write(16'h00FF, 32'h7777_0001, 1'b0, "wr0ff");
      do_read(16'hA2FF, "rdA2ff_alias");
   endtask

   task automatic test_random();
      logic [AS-1:0] a;
      int op, low;
      for (int i = 0; i < 80; i++) begin
         op  = int'($urandom_range(0, 4));
         low = int'($urandom_range(8'h60, 8'h67));
         a   = AS'(($urandom_range(0, 255) << 8) | low);
         case (op)
            0, 1: do_write(a, DS'($urandom), 1'b0, "rnd_wr");
            2:    do_write(a, DS'($urandom), 1'b1, "rnd_both");
            3:    if (written[low]) do_read(a, "rnd_rd");
                  else do_write(a, DS'($urandom), 1'b0, "rnd_wr0");
            default: idle_check(int'($urandom_range(1, 3)), "rnd_gap");
         endcase
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = '0; written[i] = 1'b0;
      end
      @(posedge clock); #1;
      test_reset();
      test_write_read();
      test_read_write_both();
      test_back_to_back();
      test_forward();
      test_reset_abort();
      test_alias();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
